// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU data-memory responder: FSM states,
// default widths and the memory-mapped output address.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 12;

    localparam logic [11:0] MMIO_ADDR = 12'hFFF;

endpackage

// File: rtl/data_mem_array.sv
// Single-port synchronous RAM, DEPTH x DATA_W, with write enable and a
// registered read port. Contents are never cleared by reset.
module data_mem_array
    import cpu_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rdata_r;
    logic [IDX_W-1:0]  idx_s;

    assign idx_s = addr[IDX_W-1:0];
    assign rdata = rdata_r;

    // Storage write port; the controller only asserts we for in-range words.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[idx_s] <= wdata;
        end
    end

    // Registered read of the currently addressed word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_r <= {DATA_W{1'b0}};
        end else begin
            rdata_r <= mem_r[idx_s];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the CPU data-memory interface: wait-state FSM, error
// decode and RAM access. Define DATA_MEM_MMIO_EN to add the mmio_out register.
module data_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DEPTH       = 4096,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] data_mem_in,
    output logic [DATA_W-1:0] data_mem_out,
    output logic              mem_ready,
    output logic              mem_err
`ifdef DATA_MEM_MMIO_EN
   ,output logic [DATA_W-1:0] mmio_out
`endif
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    mem_state_e        state_r, state_nx_s;
    logic [3:0]        cnt_r, cnt_nx_s;
    logic              rd_r, wr_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r, dout_r, ram_rdata_s;
    logic              ready_r, err_r;
    logic              capture_s, access_s, release_s;
    logic              is_mmio_s, bad_s, ram_we_s;
    logic [ADDR_W-1:0] ram_addr_s;
`ifdef DATA_MEM_MMIO_EN
    logic [DATA_W-1:0] mmio_r;
    assign is_mmio_s = (addr_r == ADDR_W'(MMIO_ADDR));
    assign mmio_out  = mmio_r;
`else
    assign is_mmio_s = 1'b0;
`endif

    assign bad_s = (rd_r & wr_r) | (({1'b0, addr_r} >= DEPTH_L) & ~is_mmio_s);
    assign ram_we_s = access_s & wr_r & ~bad_s & ~is_mmio_s;
    // While idle the RAM pre-reads the incoming address, so its registered
    // output already holds the latched word by the time the access edge comes.
    assign ram_addr_s = (state_r == IDLE) ? ram_addr : addr_r;

    assign data_mem_out = dout_r;
    assign mem_ready    = ready_r;
    assign mem_err      = err_r;

    // Next-state and wait-counter logic.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        capture_s  = 1'b0;
        access_s   = 1'b0;
        release_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (mem_rd | mem_wr) begin
                    capture_s  = 1'b1;
                    cnt_nx_s   = 4'(WAIT_STATES);
                    state_nx_s = WAIT;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd0) begin
                    access_s   = 1'b1;
                    state_nx_s = RESP;
                end else begin
                    cnt_nx_s = cnt_r - 4'd1;
                end
            end
            RESP: begin
                if (!(mem_rd | mem_wr)) begin
                    release_s  = 1'b1;
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = RESP;
                end
            end
            default: begin
                state_nx_s = IDLE;
                cnt_nx_s   = 4'd0;
            end
        endcase
    end

    // State, request latch and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            rd_r    <= 1'b0;
            wr_r    <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
            dout_r  <= {DATA_W{1'b0}};
            ready_r <= 1'b0;
            err_r   <= 1'b0;
`ifdef DATA_MEM_MMIO_EN
            mmio_r  <= {DATA_W{1'b0}};
`endif
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            if (capture_s) begin
                rd_r    <= mem_rd;
                wr_r    <= mem_wr;
                addr_r  <= ram_addr;
                wdata_r <= data_mem_in;
            end
            if (access_s) begin
                ready_r <= 1'b1;
                err_r   <= bad_s;
                if (bad_s) begin
                    dout_r <= {DATA_W{1'b0}};
                end else if (rd_r) begin
`ifdef DATA_MEM_MMIO_EN
                    dout_r <= is_mmio_s ? mmio_r : ram_rdata_s;
`else
                    dout_r <= ram_rdata_s;
`endif
                end
`ifdef DATA_MEM_MMIO_EN
                if (wr_r && is_mmio_s && !bad_s) begin
                    mmio_r <= wdata_r;
                end
`endif
            end else if (release_s) begin
                ready_r <= 1'b0;
                err_r   <= 1'b0;
            end
        end
    end

    data_mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we_s),
        .addr  (ram_addr_s),
        .wdata (wdata_r),
        .rdata (ram_rdata_s)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (2 wait states / 1024 words and
// 0 wait states / 4096 words) checked against an array-based memory model.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mrd   [2];
    logic        mwr   [2];
    logic [11:0] maddr [2];
    logic [31:0] mdin  [2];
    logic [31:0] mdout [2];
    logic        mrdy  [2];
    logic        merr  [2];
    logic [31:0] mmio  [2];

    int vectors    = 0;
    int miscompares = 0;

    logic [31:0] mem_m  [2][4096];
    logic [31:0] last_m [2];
    logic [31:0] mmio_m [2];
    int          depth_m [2] = '{1024, 4096};
    int          ws_m    [2] = '{2, 0};
    logic [11:0] pool [0:19] = '{12'h000, 12'h001, 12'h002, 12'h003, 12'h004,
                                 12'h005, 12'h006, 12'h007, 12'h008, 12'h009,
                                 12'h00A, 12'h00B, 12'h010, 12'h020, 12'h030,
                                 12'h3FF, 12'h400, 12'h7FF, 12'hABC, 12'hFFF};
`ifdef DATA_MEM_MMIO_EN
    localparam bit MMIO_EN = 1'b1;
`else
    localparam bit MMIO_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    data_mem_responder #(.DATA_W(32), .ADDR_W(12), .DEPTH(1024), .WAIT_STATES(2)) u_dut_a (
        .clk(clk), .reset(rst), .mem_rd(mrd[0]), .mem_wr(mwr[0]), .ram_addr(maddr[0]),
        .data_mem_in(mdin[0]), .data_mem_out(mdout[0]), .mem_ready(mrdy[0]), .mem_err(merr[0])
`ifdef DATA_MEM_MMIO_EN
       ,.mmio_out(mmio[0])
`endif
    );

    data_mem_responder #(.DATA_W(32), .ADDR_W(12), .DEPTH(4096), .WAIT_STATES(0)) u_dut_b (
        .clk(clk), .reset(rst), .mem_rd(mrd[1]), .mem_wr(mwr[1]), .ram_addr(maddr[1]),
        .data_mem_in(mdin[1]), .data_mem_out(mdout[1]), .mem_ready(mrdy[1]), .mem_err(merr[1])
`ifdef DATA_MEM_MMIO_EN
       ,.mmio_out(mmio[1])
`endif
    );

`ifndef DATA_MEM_MMIO_EN
    assign mmio[0] = 32'd0;
    assign mmio[1] = 32'd0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete four-phase transaction on instance s, checked against the model.
    task automatic xact(input int s, input bit rd, input bit wr,
                        input logic [11:0] a, input logic [31:0] d);
        bit          is_mm, bad;
        logic [31:0] exp_d;
        int          n;
        is_mm = MMIO_EN && (a == 12'hFFF);
        bad   = (rd && wr) || ((int'(a) >= depth_m[s]) && !is_mm);
        if (bad)     exp_d = 32'd0;
        else if (rd) exp_d = is_mm ? mmio_m[s] : mem_m[s][a];
        else         exp_d = last_m[s];
        if (!bad && wr) begin
            if (is_mm) mmio_m[s] = d;
            else       mem_m[s][a] = d;
        end
        last_m[s] = exp_d;

        @(negedge clk);
        mrd[s] = rd; mwr[s] = wr; maddr[s] = a; mdin[s] = d;
        @(posedge clk);
        #1;
        chk("ready_low_after_capture", 32'(mrdy[s]), 32'd0);
        maddr[s] = 12'($urandom);
        mdin[s]  = $urandom;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!mrdy[s] && n < 40);
        chk("ready_latency", 32'(n), 32'(ws_m[s] + 1));
        chk("err", 32'(merr[s]), 32'(bad));
        chk("dout", mdout[s], exp_d);
        chk("mmio", mmio[s], MMIO_EN ? mmio_m[s] : 32'd0);
        @(posedge clk);
        #1;
        chk("ready_held", 32'(mrdy[s]), 32'd1);
        chk("err_held", 32'(merr[s]), 32'(bad));
        @(negedge clk);
        mrd[s] = 1'b0; mwr[s] = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_release", 32'(mrdy[s]), 32'd0);
        chk("err_release", 32'(merr[s]), 32'd0);
        chk("dout_after_release", mdout[s], exp_d);
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            mrd[s] = 1'b0; mwr[s] = 1'b0; maddr[s] = 12'd0; mdin[s] = 32'd0;
            last_m[s] = 32'd0; mmio_m[s] = 32'd0;
        end
        #12;
        for (int s = 0; s < 2; s++) begin
            chk("reset_dout", mdout[s], 32'd0);
            chk("reset_ready", 32'(mrdy[s]), 32'd0);
            chk("reset_err", 32'(merr[s]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;

        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 20; i++)
                xact(s, 1'b0, 1'b1, pool[i], $urandom);

        xact(0, 1'b0, 1'b1, 12'h010, 32'hDEADBEEF);
        xact(0, 1'b1, 1'b0, 12'h010, 32'h0);
        xact(1, 1'b0, 1'b1, 12'h000, 32'h0);
        xact(1, 1'b1, 1'b0, 12'h000, 32'hFFFFFFFF);
        xact(0, 1'b0, 1'b1, 12'h020, 32'h12345678);
        xact(0, 1'b1, 1'b1, 12'h020, 32'h87654321);
        xact(0, 1'b1, 1'b0, 12'h020, 32'h0);
        xact(0, 1'b0, 1'b1, 12'h400, 32'h55555555);
        xact(0, 1'b1, 1'b0, 12'h400, 32'h0);

        xact(0, 1'b0, 1'b1, 12'h030, 32'h11111111);
        xact(0, 1'b1, 1'b0, 12'h010, 32'h0);
        @(negedge clk);
        mwr[0] = 1'b1; maddr[0] = 12'h030; mdin[0] = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midreset_ready", 32'(mrdy[0]), 32'd0);
        chk("midreset_err", 32'(merr[0]), 32'd0);
        chk("midreset_dout", mdout[0], 32'd0);
        @(negedge clk);
        rst = 1'b1; mwr[0] = 1'b0;
        for (int s = 0; s < 2; s++) begin
            last_m[s] = 32'd0; mmio_m[s] = 32'd0;
        end
        xact(0, 1'b1, 1'b0, 12'h030, 32'h0);

`ifdef DATA_MEM_MMIO_EN
        xact(0, 1'b0, 1'b1, 12'hFFF, 32'h000000A5);
        xact(0, 1'b1, 1'b0, 12'hFFF, 32'h0);
`endif

        for (int k = 0; k < 60; k++) begin
            int s, op;
            s  = int'($urandom_range(0, 1));
            op = int'($urandom_range(0, 3));
            xact(s, op != 0, op == 0 || op == 3, pool[$urandom_range(0, 19)], $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the CPU data-memory interface: accepts mem_rd/mem_wr requests with ram_addr and data_mem_in, and returns data_mem_out.
- Holds a word-addressed 32-bit RAM and adds configurable wait states with a ready handshake.
- Flags illegal requests on mem_err.
- Sits between the CPU top level and the system bus, replacing the zero-latency ideal memory.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 12, word address width; matches ram_addr.
- DEPTH, 4096, number of implemented words; must be ≤ 2**ADDR_W.
- WAIT_STATES, 2, extra cycles between request capture and response; legal range 0..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- mem_rd  in  1  read request; held by initiator until mem_ready.
- mem_wr  in  1  write request; held by initiator until mem_ready.
- ram_addr  in  ADDR_W  word address.
- data_mem_in  in  DATA_W  write data.
- data_mem_out  out  DATA_W  registered read data.
- mem_ready  out  1  response valid/complete.
- mem_err  out  1  error qualifier, valid while mem_ready=1.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; wait counter=0; data_mem_out=0; mem_ready=0; mem_err=0.
  - RAM contents are not cleared.
  - Reset mid-request aborts it; no RAM write occurs unless it already committed on an earlier edge.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On an edge with mem_rd|mem_wr=1, latch mem_rd, mem_wr, ram_addr and data_mem_in.
  - Load counter=WAIT_STATES and go to WAIT.
  - Input changes after capture are ignored until the next IDLE.
- WAIT:
  - If counter==0, perform the access on this edge and go to RESP; else decrement.
  - mem_ready is first high WAIT_STATES+1 edges after the capture edge.
- Access on WAIT→RESP edge:
  - Write: RAM[addr] <= latched data.
  - Read: data_mem_out <= RAM[addr].
  - Error cases (mem_err=1, no RAM write, data_mem_out <= 0):
    - rd and wr both latched high;
    - latched addr ≥ DEPTH.
- RESP:
  - mem_ready=1 and mem_err is held stable.
  - Stay in RESP while mem_rd|mem_wr=1 (four-phase release).
  - When both are low, go to IDLE and clear mem_ready and mem_err on that edge.
  - A new request cannot be captured in the same edge that leaves RESP.
- data_mem_out holds the last read value until the next read or error completes; writes do not change it.
- Counter width is 4 bits; no wrap, since it only counts down to 0.
- Back-to-back requests: minimum turnaround is WAIT_STATES+3 edges per access (capture, waits, RESP, release).

Optional Feature:
- Macro DATA_MEM_MMIO_EN.
- When defined:
  - Adds port mmio_out  out  DATA_W, reset 0.
  - Address all-ones (12'hFFF) is a memory-mapped output register, not RAM.
  - A write there updates mmio_out at the access edge.
  - A read returns mmio_out.
  - Never an error, regardless of DEPTH.
- When undefined: the port is absent and 12'hFFF is ordinary RAM, or an error if ≥ DEPTH.

Decomposition:
- Shared package cpu_mem_pkg holds:
  - state enum (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - DATA_W/ADDR_W defaults;
  - MMIO_ADDR constant 12'hFFF.
- One natural sub-module, data_mem_array: single-port synchronous RAM (DEPTH×DATA_W, write enable, registered read).
- FSM, counter, error decode and MMIO stay in the top.

Test Plan:
- Write 0xDEADBEEF to addr 0x010 with WAIT_STATES=2, then read 0x010 → mem_ready rises 3 edges after each capture; read returns 0xDEADBEEF; mem_err=0.
- WAIT_STATES=0: read addr 0x000 after reset → mem_ready on the 1st edge after capture; data_mem_out=0x00000000 (after prior write of 0 via init write).
- mem_rd=mem_wr=1 at addr 0x020 holding 0x12345678 → mem_ready with mem_err=1; a subsequent read of 0x020 still returns 0x12345678.
- DEPTH=1024: write to addr 0x400 → mem_err=1, no write; read of 0x400 → data_mem_out=0, mem_err=1.
- Assert reset=0 during WAIT of a write of 0xCAFEF00D to 0x030 (prior content 0x11111111) → outputs 0 immediately; read of 0x030 after release returns 0x11111111.
- DATA_MEM_MMIO_EN: write 0x000000A5 to 0xFFF → mmio_out=0x000000A5 at the access edge; read 0xFFF returns 0x000000A5; mem_err=0.
